// File: rtl/ppi_bus_master.sv
// Host-side sequencer for an 8255 PPI: turns single-beat read/write commands into a
// CS#/A1/A0/RD#/WR# bus cycle with programmable setup, strobe and hold lengths.
module ppi_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       ppi_cs_n,
  output logic       ppi_rd_n,
  output logic       ppi_wr_n,
  output logic       ppi_a1,
  output logic       ppi_a0,
  output logic [7:0] ppi_d_out,
  output logic       ppi_d_oe,
  input  logic [7:0] ppi_d_in
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StErr} state_e;

  // Counter holds the remaining cycles of the current phase minus one.
  localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic       a1_q, a1_d, a0_q, a0_d, d_oe_q, d_oe_d;
  logic [7:0] d_out_q, d_out_d, rbuf_q, rbuf_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    cs_n_d      = cs_n_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    a1_d        = a1_q;
    a0_d        = a0_q;
    d_oe_d      = d_oe_q;
    d_out_d     = d_out_q;
    rbuf_d      = rbuf_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rd_d = cmd_rd;
          if (cmd_rd && (cmd_addr == 2'd3)) begin
            state_d = StErr;
          end else begin
            state_d = StSetup;
            cnt_d   = SetupLd;
            cs_n_d  = 1'b0;
            a1_d    = cmd_addr[1];
            a0_d    = cmd_addr[0];
            if (!cmd_rd) begin
              d_oe_d  = 1'b1;
              d_out_d = cmd_wdata;
            end
          end
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
          rd_n_d  = ~rd_q;
          wr_n_d  = rd_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          if (rd_q) begin
            rbuf_d = ppi_d_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          cs_n_d  = 1'b1;
          d_oe_d  = 1'b0;
          if (rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = rbuf_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 8'hFF;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rd_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      a1_q        <= 1'b0;
      a0_q        <= 1'b0;
      d_oe_q      <= 1'b0;
      d_out_q     <= 8'h00;
      rbuf_q      <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      a1_q        <= a1_d;
      a0_q        <= a0_d;
      d_oe_q      <= d_oe_d;
      d_out_q     <= d_out_d;
      rbuf_q      <= rbuf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ppi_cs_n  = cs_n_q;
  assign ppi_rd_n  = rd_n_q;
  assign ppi_wr_n  = wr_n_q;
  assign ppi_a1    = a1_q;
  assign ppi_a0    = a0_q;
  assign ppi_d_out = d_out_q;
  assign ppi_d_oe  = d_oe_q;

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
- Synchronous host-side sequencer that sits directly upstream of the PPI8255 block.
- Converts single-beat commands (read/write, 2-bit port address, 8-bit data) into a 8255 bus cycle: CS#, A1/A0, RD#/WR# and the data bus.
- Phases are setup, strobe and hold, each with a programmable length in clocks.
- Returns read data through a one-cycle response pulse.

Parameters:
- SETUP_CYC, 1, clocks with CS#/address (and write data) valid before the strobe; legal range 1..15.
- STROBE_CYC, 2, clocks RD# or WR# is held low; legal range 1..15.
- HOLD_CYC, 1, clocks CS#/address/data are held after the strobe rises; legal range 1..15.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, high only in IDLE; a command is accepted on a clk edge where cmd_valid && cmd_ready.
- cmd_rd, input, 1, 1 = read, 0 = write.
- cmd_addr, input, 2, {A1,A0}: 0 = PORTA, 1 = PORTB, 2 = PORTC, 3 = control word.
- cmd_wdata, input, 8, write data or control word.
- rsp_valid, output, 1, one-cycle pulse on read completion.
- rsp_rdata, output, 8, read data; valid with rsp_valid and held until the next response.
- rsp_err, output, 1, qualifies rsp_valid; marks an illegal read.
- busy, output, 1, equals ~cmd_ready.
- ppi_cs_n, output, 1, chip select to the PPI.
- ppi_rd_n, output, 1, read strobe to the PPI.
- ppi_wr_n, output, 1, write strobe to the PPI.
- ppi_a1, output, 1, address bit 1 to the PPI.
- ppi_a0, output, 1, address bit 0 to the PPI.
- ppi_d_out, output, 8, data driven toward the PPI data bus.
- ppi_d_oe, output, 1, data bus output enable; the top-level tristate drives ppi_d_out when high.
- ppi_d_in, input, 8, PPI data bus sampled by this block.

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - State goes to IDLE.
  - ppi_cs_n=1, ppi_rd_n=1, ppi_wr_n=1, ppi_a1=0, ppi_a0=0, ppi_d_out=0, ppi_d_oe=0.
  - cmd_ready=1 once rst_n is high; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - No partial strobe survives reset.
- All ppi_* outputs are registered (glitch-free). RD# and WR# are never low simultaneously.
- Acceptance:
  - cmd_rd, cmd_addr and cmd_wdata are captured on the accepting edge.
  - Later changes on cmd_* are ignored until the next acceptance.
- State machine: IDLE, SETUP, STROBE, HOLD, ERR. A 4-bit down-counter times each phase.
- IDLE:
  - cmd_ready=1, cs_n=1, d_oe=0; A1/A0 keep their last value.
  - Accepting read with addr=3 -> ERR.
  - Any other accept -> SETUP.
- SETUP (SETUP_CYC clocks):
  - cs_n=0 and A1/A0 = captured address.
  - For writes: d_oe=1 and d_out = captured data.
  - Then -> STROBE.
- STROBE (STROBE_CYC clocks):
  - Write: wr_n=0. Read: rd_n=0.
  - For reads, ppi_d_in is registered into the read buffer on the clock edge that ends the last strobe cycle.
  - Then -> HOLD.
- HOLD (HOLD_CYC clocks):
  - rd_n=wr_n=1; cs_n, address and d_oe/d_out unchanged.
  - Then -> IDLE.
- Completion:
  - On the first IDLE cycle after HOLD, reads give rsp_valid=1, rsp_rdata = captured byte, rsp_err=0.
  - Writes produce no response; completion is cmd_ready returning high.
- ERR (exactly 1 clock):
  - No bus activity; cs_n stays 1.
  - Then -> IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF.
- Latency, counting the accepting edge as cycle 0:
  - Strobe is low in cycles SETUP_CYC+1 .. SETUP_CYC+STROBE_CYC.
  - The response/ready cycle is SETUP_CYC+STROBE_CYC+HOLD_CYC+1; with defaults this is cycle 5.
- Back-to-back: a new command may be accepted in the same cycle rsp_valid is high. Minimum command spacing is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 clocks.
- cmd_valid while busy is held off (cmd_ready=0); no queueing.

Test Plan:
- Reset, then idle 3 clocks -> all ppi_* at reset values; cmd_ready=1, rsp_valid=0.
- Defaults; write addr=3, data=8'h80 -> cs_n low cycles 1-4; wr_n low cycles 2-3; a1=a0=1; d_oe=1 with d_out=8'h80 cycles 1-4; cmd_ready high at cycle 5; no rsp_valid.
- Defaults; read addr=0 with ppi_d_in=8'hA5 during strobe -> rd_n low cycles 2-3; wr_n stays 1; rsp_valid pulse at cycle 5 with rsp_rdata=8'hA5, rsp_err=0; d_oe never high.
- Read addr=3 -> no cs_n activity; rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF at cycle 2.
- Write addr=1 (8'h0F) accepted, then a read addr=2 accepted in the cycle cmd_ready returns -> second cycle starts with no gap; cmd_* toggling mid-transaction has no effect on the bus.
- SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2; read, with rst_n pulsed low in the second strobe cycle -> rd_n/cs_n return high asynchronously; no rsp_valid; next read completes normally at cycle 8.
